// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx
// UART receiver (8N1, LSB first) plus a 4-byte register-write frame parser.
// Frame layout: SYNC_BYTE, address, data, checksum (SYNC_BYTE ^ addr ^ data).
//
// Ports:
//   clk           system clock, the only clock
//   I_rst_n       asynchronous active-low reset
//   uart_rx       serial line, idle high, asynchronous to clk
//   rx_byte       last correctly framed byte
//   rx_byte_valid one-cycle pulse, rx_byte valid in that cycle
//   rx_frame_err  one-cycle pulse, stop bit sampled low
//   rx_busy       high from start-bit detection until the stop-bit sample
//   reg_wr_en     one-cycle write strobe for an accepted frame
//   reg_addr      register address, held until the next accepted frame
//   reg_wdata     register data, held until the next accepted frame
//   csum_err      one-cycle pulse, complete frame with a bad checksum
//
// Byte FSM
//   state   | meaning
//   B_IDLE  | line idle, waiting for a falling edge on rxs
//   B_START | half a bit time to the middle of the start bit
//   B_DATA  | eight mid-bit samples, LSB first
//   B_STOP  | one bit time to the middle of the stop bit
//   B_BREAK | stop bit was low, wait for the line to return high
//
// Parser FSM
//   state       | meaning
//   P_WAIT_SYNC | hunting for SYNC_BYTE
//   P_GET_ADDR  | next byte is the address
//   P_GET_DATA  | next byte is the data
//   P_GET_CSUM  | next byte is the checksum

module uart_cmd_rx #(
   parameter int         CLK_FREQ     = 27_000_000,
   parameter int         BAUD         = 115_200,
   parameter logic [7:0] SYNC_BYTE    = 8'hA5,
   parameter int         TIMEOUT_BITS = 20
) (
   input  logic       clk,
   input  logic       I_rst_n,
   input  logic       uart_rx,
   output logic [7:0] rx_byte,
   output logic       rx_byte_valid,
   output logic       rx_frame_err,
   output logic       rx_busy,
   output logic       reg_wr_en,
   output logic [7:0] reg_addr,
   output logic [7:0] reg_wdata,
   output logic       csum_err
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int TIMEOUT_CLKS = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int CNT_W        = $clog2(CLKS_PER_BIT);
   localparam int TO_W         = $clog2(TIMEOUT_CLKS + 1);

   localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF_BIT - 1);
   localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CLKS - 1);

   typedef enum logic [2:0] {B_IDLE, B_START, B_DATA, B_STOP, B_BREAK} byte_state_t;
   typedef enum logic [1:0] {P_WAIT_SYNC, P_GET_ADDR, P_GET_DATA, P_GET_CSUM} parse_state_t;

   // ------------------------------------------------------------------
   // Synchronizer and falling-edge detect
   // ------------------------------------------------------------------
   logic [1:0] sync_q;
   logic [1:0] fill_q;
   logic       rxs;
   logic       rxs_prev;
   logic       armed;
   logic       fall;

   assign rxs = sync_q[1];

   // fill_q marks when sync_q holds real line samples rather than reset
   // values, so a line held low through reset release is not mistaken for
   // a start bit; armed only sets once a genuine high level is seen.
   always_ff @(posedge clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         sync_q   <= 2'b11;
         fill_q   <= 2'b00;
         rxs_prev <= 1'b1;
         armed    <= 1'b0;
      end else begin
         sync_q   <= {sync_q[0], uart_rx};
         fill_q   <= {fill_q[0], 1'b1};
         rxs_prev <= rxs;
         if (fill_q[1] && rxs)
            armed <= 1'b1;
      end
   end

   assign fall = armed & rxs_prev & ~rxs;

   // ------------------------------------------------------------------
   // Byte FSM
   // ------------------------------------------------------------------
   byte_state_t      bstate, bstate_nxt;
   logic [CNT_W-1:0] cnt_q;
   logic [2:0]       bit_idx_q;
   logic [7:0]       shift_q;
   logic             tick;
   logic             stop_ok;
   logic             stop_bad;

   assign tick = (cnt_q == '0);

   always_ff @(posedge clk or negedge I_rst_n) begin
      if (!I_rst_n) bstate <= B_IDLE;
      else          bstate <= bstate_nxt;
   end

   always_comb begin
      bstate_nxt = bstate;
      case (bstate)
         B_IDLE:  if (fall) bstate_nxt = B_START;
         B_START: if (tick) bstate_nxt = rxs ? B_IDLE : B_DATA;
         B_DATA:  if (tick && bit_idx_q == 3'd7) bstate_nxt = B_STOP;
         B_STOP:  if (tick) bstate_nxt = rxs ? B_IDLE : B_BREAK;
         B_BREAK: if (rxs) bstate_nxt = B_IDLE;
         default: bstate_nxt = B_IDLE;
      endcase
   end

   always_comb begin
      rx_busy  = (bstate == B_START) || (bstate == B_DATA) || (bstate == B_STOP);
      stop_ok  = (bstate == B_STOP) && tick && rxs;
      stop_bad = (bstate == B_STOP) && tick && !rxs;
   end

   always_ff @(posedge clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         cnt_q         <= '0;
         bit_idx_q     <= 3'd0;
         shift_q       <= 8'h00;
         rx_byte       <= 8'h00;
         rx_byte_valid <= 1'b0;
         rx_frame_err  <= 1'b0;
      end else begin
         rx_byte_valid <= stop_ok;
         rx_frame_err  <= stop_bad;
         if (stop_ok)
            rx_byte <= shift_q;
         case (bstate)
            B_IDLE: begin
               if (fall)
                  cnt_q <= HALF_LOAD;
            end
            B_START: begin
               if (tick) begin
                  cnt_q     <= BIT_LOAD;
                  bit_idx_q <= 3'd0;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            B_DATA: begin
               if (tick) begin
                  shift_q   <= {rxs, shift_q[7:1]};
                  bit_idx_q <= bit_idx_q + 3'd1;
                  cnt_q     <= BIT_LOAD;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            B_STOP: begin
               if (!tick)
                  cnt_q <= cnt_q - 1'b1;
            end
            default: ;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Frame parser
   // ------------------------------------------------------------------
   parse_state_t    pstate, pstate_nxt;
   logic [7:0]      addr_q;
   logic [7:0]      data_q;
   logic [TO_W-1:0] to_cnt_q;
   logic            frame_ok;
   logic            frame_bad;
   logic            timeout_hit;

   always_ff @(posedge clk or negedge I_rst_n) begin
      if (!I_rst_n) pstate <= P_WAIT_SYNC;
      else          pstate <= pstate_nxt;
   end

   always_comb begin
      pstate_nxt = pstate;
      if (pstate == P_WAIT_SYNC) begin
         if (rx_byte_valid && rx_byte == SYNC_BYTE)
            pstate_nxt = P_GET_ADDR;
      end else if (rx_frame_err || timeout_hit) begin
         pstate_nxt = P_WAIT_SYNC;
      end else if (rx_byte_valid) begin
         case (pstate)
            P_GET_ADDR: pstate_nxt = P_GET_DATA;
            P_GET_DATA: pstate_nxt = P_GET_CSUM;
            default:    pstate_nxt = P_WAIT_SYNC;
         endcase
      end
   end

   // The gap counter only advances while the byte receiver is idle, so it
   // measures line-idle time between bytes rather than time on the wire.
   // A byte arriving on the terminal cycle takes priority over the timeout.
   always_comb begin
      frame_ok    = (pstate == P_GET_CSUM) && rx_byte_valid &&
                    (rx_byte == (SYNC_BYTE ^ addr_q ^ data_q));
      frame_bad   = (pstate == P_GET_CSUM) && rx_byte_valid &&
                    (rx_byte != (SYNC_BYTE ^ addr_q ^ data_q));
      timeout_hit = (pstate != P_WAIT_SYNC) && !rx_byte_valid && !rx_busy &&
                    (to_cnt_q == TO_LAST);
   end

   always_ff @(posedge clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         addr_q    <= 8'h00;
         data_q    <= 8'h00;
         to_cnt_q  <= '0;
         reg_addr  <= 8'h00;
         reg_wdata <= 8'h00;
         reg_wr_en <= 1'b0;
         csum_err  <= 1'b0;
      end else begin
         reg_wr_en <= frame_ok;
         csum_err  <= frame_bad;
         if (frame_ok) begin
            reg_addr  <= addr_q;
            reg_wdata <= data_q;
         end
         if (pstate == P_GET_ADDR && rx_byte_valid)
            addr_q <= rx_byte;
         if (pstate == P_GET_DATA && rx_byte_valid)
            data_q <= rx_byte;
         if (pstate == P_WAIT_SYNC || rx_byte_valid || rx_frame_err || timeout_hit)
            to_cnt_q <= '0;
         else if (!rx_busy)
            to_cnt_q <= to_cnt_q + 1'b1;
      end
   end

endmodule
